// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns {a..g}, display codes and
// the capture FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_L     = 7'b0001110;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_P     = 7'b1100111;
  localparam logic [6:0] SEG_N     = 7'b1110110;
  localparam logic [6:0] SEG_A     = 7'b1110111;

  localparam logic [3:0] CODE_0     = 4'h0;
  localparam logic [3:0] CODE_1     = 4'h1;
  localparam logic [3:0] CODE_2     = 4'h2;
  localparam logic [3:0] CODE_3     = 4'h3;
  localparam logic [3:0] CODE_4     = 4'h4;
  localparam logic [3:0] CODE_5     = 4'h5;
  localparam logic [3:0] CODE_6     = 4'h6;
  localparam logic [3:0] CODE_7     = 4'h7;
  localparam logic [3:0] CODE_8     = 4'h8;
  localparam logic [3:0] CODE_9     = 4'h9;
  localparam logic [3:0] CODE_L     = 4'hA;
  localparam logic [3:0] CODE_C     = 4'hB;
  localparam logic [3:0] CODE_BLANK = 4'hC;
  localparam logic [3:0] CODE_P     = 4'hD;
  localparam logic [3:0] CODE_N     = 4'hE;
  localparam logic [3:0] CODE_A     = 4'hF;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to display-code decoder; valid is low for
// any pattern outside the 16-entry table.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] code,
  output logic       valid
);

  // NOTE: every output gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    code  = CODE_0;
    valid = 1'b1;
    case (seg_in)
      SEG_0:     code = CODE_0;
      SEG_1:     code = CODE_1;
      SEG_2:     code = CODE_2;
      SEG_3:     code = CODE_3;
      SEG_4:     code = CODE_4;
      SEG_5:     code = CODE_5;
      SEG_6:     code = CODE_6;
      SEG_7:     code = CODE_7;
      SEG_8:     code = CODE_8;
      SEG_9:     code = CODE_9;
      SEG_L:     code = CODE_L;
      SEG_C:     code = CODE_C;
      SEG_BLANK: code = CODE_BLANK;
      SEG_P:     code = CODE_P;
      SEG_N:     code = CODE_N;
      SEG_A:     code = CODE_A;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Scanned 7-segment bus capture: debounces each {pattern, select} sample run,
// decodes it and keeps a per-digit code bank with change strobe.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int STABLE = 3,
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   codes,
  output logic [DIGITS-1:0]     code_err,
  output logic                  upd,
  output logic [IDX_W-1:0]      upd_idx
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [6:0]        prev_seg;
  logic [DIGITS-1:0] prev_sel;
  logic [3:0]        cnt, cnt_next;
  logic [1:0]        state, state_next;
  logic              onehot, same, commit, changed;
  logic [IDX_W-1:0]  sel_idx;
  logic [3:0]        dec_code, cur_code;
  logic              dec_valid, cur_err;

  seg7_decode u_decode (
    .seg_in (seg_in),
    .code   (dec_code),
    .valid  (dec_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign onehot   = $onehot(dig_sel);
  assign same     = onehot && (seg_in == prev_seg) && (dig_sel == prev_sel);
  assign cur_code = codes[4*sel_idx +: 4];
  assign cur_err  = code_err[sel_idx];

  always_comb begin
    cnt_next   = 4'd0;
    state_next = IDLE;
    if (onehot) begin
      if (!same)                cnt_next = 4'd1;
      else if (cnt < STABLE_C)  cnt_next = cnt + 4'd1;
      else                      cnt_next = cnt;
      state_next = (cnt_next == STABLE_C) ? HELD : TRACK;
    end
  end

  // A sample that already committed stays in HELD and must not commit again.
  assign commit  = onehot && (cnt_next == STABLE_C) && !(same && state == HELD);
  assign changed = dec_valid ? ((cur_code != dec_code) || cur_err) : !cur_err;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the code bank is reset explicitly; readers rely on it showing
      // code 0 / no error before any digit has been observed.
      codes    <= '0;
      code_err <= '0;
      upd      <= 1'b0;
      upd_idx  <= '0;
      cnt      <= 4'd0;
      state    <= IDLE;
      prev_seg <= '0;
      prev_sel <= '0;
    end else begin
      prev_seg <= seg_in;
      prev_sel <= dig_sel;
      cnt      <= cnt_next;
      state    <= state_next;
      upd      <= commit && changed;
      if (commit) begin
        upd_idx           <= sel_idx;
        code_err[sel_idx] <= !dec_valid;
        if (dec_valid) codes[4*sel_idx +: 4] <= dec_code;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected commits go into a scoreboard
// queue, a negedge monitor pops one entry per upd pulse and compares.
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] codes;
    logic [3:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] codes;
  logic [3:0]  code_err;
  logic        upd;
  logic [1:0]  upd_idx;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_in),
    .dig_sel  (dig_sel),
    .codes    (codes),
    .code_err (code_err),
    .upd      (upd),
    .upd_idx  (upd_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_in  = s;
    dig_sel = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_upd(input logic [1:0] idx, input logic [15:0] c, input logic [3:0] e);
    exp_t x;
    x.idx   = idx;
    x.codes = c;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && upd) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_upd: upd=1 idx=%0d codes=%h, expected no pulse (t=%0t)",
                 upd_idx, codes, $time);
      end else begin
        e = sb.pop_front();
        check("upd_idx", 32'(upd_idx), 32'(e.idx));
        check("upd_codes", 32'(codes), 32'(e.codes));
        check("upd_err", 32'(code_err), 32'(e.err));
      end
    end
  end

  initial begin
    reset   = 1'b1;
    seg_in  = '0;
    dig_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_codes", 32'(codes), 32'h0000);
    check("rst_err", 32'(code_err), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_idx", 32'(upd_idx), 32'h0);

    // Clean commit on digit 2: nothing after 2 edges, commit on the 3rd.
    drive(SEG_3, 4'b0100, 2);
    check("early_codes", 32'(codes), 32'h0000);
    expect_upd(2'd2, 16'h0300, 4'b0000);
    drive(SEG_3, 4'b0100, 1);
    check("clean_codes", 32'(codes), 32'h0300);
    drive(SEG_3, 4'b0100, 10);
    check("hold_idx", 32'(upd_idx), 32'h2);

    // Glitch: a 2-edge run of '2' never commits; the following '1' does.
    expect_upd(2'd0, 16'h0301, 4'b0000);
    drive(SEG_2, 4'b0001, 2);
    drive(SEG_1, 4'b0001, 3);
    check("glitch_codes", 32'(codes), 32'h0301);

    // Invalid pattern flags digit 1 and leaves its code; a valid one clears it.
    expect_upd(2'd1, 16'h0301, 4'b0010);
    drive(7'b1010101, 4'b0010, 3);
    check("inv_err", 32'(code_err), 32'h2);
    expect_upd(2'd1, 16'h03F1, 4'b0000);
    drive(SEG_A, 4'b0010, 3);
    check("fix_codes", 32'(codes), 32'h03F1);
    check("fix_err", 32'(code_err), 32'h0);

    // Same-value recommits move upd_idx but produce no upd pulse.
    expect_upd(2'd3, 16'h83F1, 4'b0000);
    drive(SEG_8, 4'b1000, 3);
    drive(SEG_1, 4'b0001, 3);
    check("same0_idx", 32'(upd_idx), 32'h0);
    check("same0_upd", 32'(upd), 32'h0);
    drive(SEG_8, 4'b1000, 3);
    check("same3_idx", 32'(upd_idx), 32'h3);
    check("same3_upd", 32'(upd), 32'h0);
    drive(SEG_8, 4'b1000, 2);

    // Multi-hot select never commits.
    drive(SEG_5, 4'b0011, 5);
    check("mhot_codes", 32'(codes), 32'h83F1);
    check("mhot_idx", 32'(upd_idx), 32'h3);

    // Reset lands on the would-be commit edge and discards the partial run.
    drive(SEG_7, 4'b0001, 2);
    reset = 1'b1;
    drive(SEG_7, 4'b0001, 1);
    reset = 1'b0;
    check("midrst_codes", 32'(codes), 32'h0000);
    check("midrst_upd", 32'(upd), 32'h0);
    check("midrst_idx", 32'(upd_idx), 32'h0);
    drive(SEG_7, 4'b0001, 2);
    check("post_rst_early", 32'(codes), 32'h0000);
    expect_upd(2'd0, 16'h0007, 4'b0000);
    drive(SEG_7, 4'b0001, 1);
    check("post_rst_codes", 32'(codes), 32'h0007);

    drive(SEG_7, 4'b0001, 3);
    check("pending_upd", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
